// File: rtl/issue_stage.sv
// Decode-to-execute issue stage: integer register file, EX/WB operand forwarding,
// load-use stall detection and a registered, flushable operand bundle toward the ALU.
module issue_stage #(
    parameter  int cXLEN      = 32,
    parameter  int cRegNum    = 32,
    parameter  int cCtrlW     = 24,
    parameter  int cStallCntW = 16,
    localparam int cAW        = $clog2(cRegNum)
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [cAW-1:0]        iRs1Addr,
    input  logic [cAW-1:0]        iRs2Addr,
    input  logic [cAW-1:0]        iRdAddr,
    input  logic                  iRs1Used,
    input  logic                  iRs2Used,
    input  logic                  iRdWrite,
    input  logic                  iIsLoad,
    input  logic [cXLEN-1:0]      iImm,
    input  logic [cXLEN-1:0]      iPc,
    input  logic [cCtrlW-1:0]     iCtrl,
    input  logic                  iFlush,
    input  logic                  iExRdWrite,
    input  logic                  iExIsLoad,
    input  logic [cAW-1:0]        iExRdAddr,
    input  logic [cXLEN-1:0]      iExData,
    input  logic                  iWbEn,
    input  logic [cAW-1:0]        iWbAddr,
    input  logic [cXLEN-1:0]      iWbData,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [cXLEN-1:0]      oRs1Data,
    output logic [cXLEN-1:0]      oRs2Data,
    output logic [cXLEN-1:0]      oImm,
    output logic [cXLEN-1:0]      oPc,
    output logic [cAW-1:0]        oRdAddr,
    output logic                  oRdWrite,
    output logic                  oIsLoad,
    output logic [cCtrlW-1:0]     oCtrl,
    output logic [cStallCntW-1:0] oStallCnt
);

    logic [cXLEN-1:0]      rf_q [cRegNum];
    logic [cXLEN-1:0]      rf_d [cRegNum];
    logic                  valid_q, valid_d;
    logic [cXLEN-1:0]      rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, pc_q, pc_d;
    logic [cAW-1:0]        rd_q, rd_d;
    logic                  rdw_q, rdw_d, ld_q, ld_d;
    logic [cCtrlW-1:0]     ctrl_q, ctrl_d;
    logic [cStallCntW-1:0] stall_q, stall_d;

    logic                  hazard, slot_free, accept;
    logic [cXLEN-1:0]      rs1_sel, rs2_sel;

    // Forwarding priority: x0, then EX (non-load) result, then WB write-through, then RF.
    function automatic logic [cXLEN-1:0] sel_opnd(
        input logic [cAW-1:0]   a,
        input logic [cXLEN-1:0] rf_val,
        input logic             ex_w,
        input logic             ex_ld,
        input logic [cAW-1:0]   ex_a,
        input logic [cXLEN-1:0] ex_d,
        input logic             wb_en,
        input logic [cAW-1:0]   wb_a,
        input logic [cXLEN-1:0] wb_d
    );
        if (a == '0)                          return '0;
        else if (ex_w && !ex_ld && ex_a == a) return ex_d;
        else if (wb_en && wb_a == a)          return wb_d;
        else                                  return rf_val;
    endfunction

    always_comb begin
        rs1_sel = sel_opnd(iRs1Addr, rf_q[iRs1Addr], iExRdWrite, iExIsLoad, iExRdAddr,
                           iExData, iWbEn, iWbAddr, iWbData);
        rs2_sel = sel_opnd(iRs2Addr, rf_q[iRs2Addr], iExRdWrite, iExIsLoad, iExRdAddr,
                           iExData, iWbEn, iWbAddr, iWbData);

        hazard = iValid && iExRdWrite && iExIsLoad && (iExRdAddr != '0) &&
                 ((iRs1Used && iRs1Addr == iExRdAddr) || (iRs2Used && iRs2Addr == iExRdAddr));
        slot_free = !valid_q || iReady;
        oReady    = slot_free && !hazard && !iFlush;
        accept    = iValid && oReady;
    end

    always_comb begin
        rf_d = rf_q;
        if (iWbEn && iWbAddr != '0) rf_d[iWbAddr] = iWbData;
    end

    always_comb begin
        valid_d = valid_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        rdw_d   = rdw_q;
        ld_d    = ld_q;
        ctrl_d  = ctrl_q;
        stall_d = stall_q;

        if (iFlush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            rs1_d   = rs1_sel;
            rs2_d   = rs2_sel;
            imm_d   = iImm;
            pc_d    = iPc;
            rd_d    = iRdAddr;
            rdw_d   = iRdWrite;
            ld_d    = iIsLoad;
            ctrl_d  = iCtrl;
        end else if (valid_q && iReady) begin
            valid_d = 1'b0;
        end

        // Only cycles that actually inject a bubble are counted; a stalled FULL slot is not.
        if (hazard && slot_free && !iFlush && stall_q != '1)
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int i = 0; i < cRegNum; i++) rf_q[i] <= '0;
            valid_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            rdw_q   <= 1'b0;
            ld_q    <= 1'b0;
            ctrl_q  <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < cRegNum; i++) rf_q[i] <= rf_d[i];
            valid_q <= valid_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            rdw_q   <= rdw_d;
            ld_q    <= ld_d;
            ctrl_q  <= ctrl_d;
            stall_q <= stall_d;
        end
    end

    assign oValid    = valid_q;
    assign oRs1Data  = rs1_q;
    assign oRs2Data  = rs2_q;
    assign oImm      = imm_q;
    assign oPc       = pc_q;
    assign oRdAddr   = rd_q;
    assign oRdWrite  = rdw_q;
    assign oIsLoad   = ld_q;
    assign oCtrl     = ctrl_q;
    assign oStallCnt = stall_q;

endmodule

// File: tb/tb_issue_stage.sv
// Directed + randomized bench for issue_stage against an architectural reference model.
module tb_issue_stage;
    localparam int XL = 32;
    localparam int CW = 24;
    localparam int SW = 3;
    localparam int AW = 5;

    logic          iClk = 1'b0, iRst = 1'b0;
    logic          iValid, oReady, iRs1Used, iRs2Used, iRdWrite, iIsLoad, iFlush;
    logic [AW-1:0] iRs1Addr, iRs2Addr, iRdAddr, iExRdAddr, iWbAddr, oRdAddr;
    logic [XL-1:0] iImm, iPc, iExData, iWbData, oRs1Data, oRs2Data, oImm, oPc;
    logic [CW-1:0] iCtrl, oCtrl;
    logic          iExRdWrite, iExIsLoad, iWbEn, oValid, iReady, oRdWrite, oIsLoad;
    logic [SW-1:0] oStallCnt;

    issue_stage #(.cXLEN(XL), .cRegNum(32), .cCtrlW(CW), .cStallCntW(SW)) dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady),
        .iRs1Addr(iRs1Addr), .iRs2Addr(iRs2Addr), .iRdAddr(iRdAddr),
        .iRs1Used(iRs1Used), .iRs2Used(iRs2Used), .iRdWrite(iRdWrite), .iIsLoad(iIsLoad),
        .iImm(iImm), .iPc(iPc), .iCtrl(iCtrl), .iFlush(iFlush),
        .iExRdWrite(iExRdWrite), .iExIsLoad(iExIsLoad), .iExRdAddr(iExRdAddr), .iExData(iExData),
        .iWbEn(iWbEn), .iWbAddr(iWbAddr), .iWbData(iWbData),
        .oValid(oValid), .iReady(iReady), .oRs1Data(oRs1Data), .oRs2Data(oRs2Data),
        .oImm(oImm), .oPc(oPc), .oRdAddr(oRdAddr), .oRdWrite(oRdWrite), .oIsLoad(oIsLoad),
        .oCtrl(oCtrl), .oStallCnt(oStallCnt)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural registers, the slot contents and the bubble count.
    logic [XL-1:0] m_regs [32];
    logic          m_valid;
    logic [XL-1:0] m_rs1, m_rs2, m_imm, m_pc;
    logic [AW-1:0] m_rd;
    logic          m_rdw, m_ld;
    logic [CW-1:0] m_ctrl;
    int            m_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_valid = 0; m_rs1 = '0; m_rs2 = '0; m_imm = '0; m_pc = '0;
        m_rd = '0; m_rdw = 0; m_ld = 0; m_ctrl = '0; m_stall = 0;
    endtask

    function automatic logic [XL-1:0] ref_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (iExRdWrite && !iExIsLoad && iExRdAddr == a) return iExData;
        if (iWbEn && iWbAddr == a) return iWbData;
        return m_regs[a];
    endfunction

    task automatic idle();
        iValid = 0; iRs1Addr = '0; iRs2Addr = '0; iRdAddr = '0; iRs1Used = 0; iRs2Used = 0;
        iRdWrite = 0; iIsLoad = 0; iImm = '0; iPc = '0; iCtrl = '0; iFlush = 0;
        iExRdWrite = 0; iExIsLoad = 0; iExRdAddr = '0; iExData = '0;
        iWbEn = 0; iWbAddr = '0; iWbData = '0; iReady = 1;
    endtask

    // One clock: check oReady mid-cycle, advance the model, then check every output after the edge.
    task automatic tick();
        logic          hz, slot, rdy;
        logic          n_valid;
        logic [XL-1:0] r1, r2;
        @(negedge iClk);
        slot = !m_valid || iReady;
        hz = iValid && iExRdWrite && iExIsLoad && iExRdAddr != 0 &&
             ((iRs1Used && iRs1Addr == iExRdAddr) || (iRs2Used && iRs2Addr == iExRdAddr));
        rdy = slot && !hz && !iFlush;
        chk("oReady", 64'(oReady), 64'(rdy));
        r1 = ref_read(iRs1Addr);
        r2 = ref_read(iRs2Addr);
        n_valid = m_valid;
        if (iFlush) n_valid = 0;
        else if (iValid && rdy) begin
            n_valid = 1; m_rs1 = r1; m_rs2 = r2; m_imm = iImm; m_pc = iPc;
            m_rd = iRdAddr; m_rdw = iRdWrite; m_ld = iIsLoad; m_ctrl = iCtrl;
        end else if (m_valid && iReady) n_valid = 0;
        if (hz && slot && !iFlush && m_stall < (1 << SW) - 1) m_stall++;
        if (iWbEn && iWbAddr != 0) m_regs[iWbAddr] = iWbData;
        m_valid = n_valid;
        @(posedge iClk);
        #1;
        chk("oValid", 64'(oValid), 64'(m_valid));
        chk("oStallCnt", 64'(oStallCnt), 64'(m_stall));
        if (m_valid) begin
            chk("oRs1Data", 64'(oRs1Data), 64'(m_rs1));
            chk("oRs2Data", 64'(oRs2Data), 64'(m_rs2));
            chk("oImm", 64'(oImm), 64'(m_imm));
            chk("oPc", 64'(oPc), 64'(m_pc));
            chk("oRdAddr", 64'(oRdAddr), 64'(m_rd));
            chk("oRdWrite", 64'(oRdWrite), 64'(m_rdw));
            chk("oIsLoad", 64'(oIsLoad), 64'(m_ld));
            chk("oCtrl", 64'(oCtrl), 64'(m_ctrl));
        end
    endtask

    task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [XL-1:0] pc);
        iValid = 1; iRs1Addr = rs1; iRs2Addr = rs2; iRs1Used = 1; iRs2Used = 1;
        iRdAddr = 5'd9; iRdWrite = 1; iPc = pc; iImm = pc + 4; iCtrl = 24'h00A0_33;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge iClk);
        #2 iRst = 1;
        #1;
        chk("rst_oValid", 64'(oValid), 64'd0);
        chk("rst_oStallCnt", 64'(oStallCnt), 64'd0);
        chk("rst_oReady", 64'(oReady), 64'd1);
        chk("rst_oPc", 64'(oPc), 64'd0);
        @(posedge iClk); #1;

        // WB x5 then read it back; x0 stays zero even when written
        iWbEn = 1; iWbAddr = 5'd5; iWbData = 32'hAA; tick();
        idle(); issue(5'd5, 5'd0, 32'h40); tick();
        chk("x5_read", 64'(oRs1Data), 64'hAA);
        chk("x0_read", 64'(oRs2Data), 64'h0);
        idle(); iWbEn = 1; iWbAddr = 5'd0; iWbData = 32'hFFFF_FFFF; tick();
        idle(); issue(5'd0, 5'd0, 32'h44); tick();
        chk("x0_after_wr", 64'(oRs1Data), 64'h0);

        // EX beats WB; once EX goes away the write-through value is in the RF
        idle(); issue(5'd7, 5'd0, 32'h48);
        iExRdWrite = 1; iExRdAddr = 5'd7; iExData = 32'h11;
        iWbEn = 1; iWbAddr = 5'd7; iWbData = 32'h22; tick();
        chk("fwd_ex", 64'(oRs1Data), 64'h11);
        idle(); issue(5'd7, 5'd0, 32'h4C); tick();
        chk("fwd_wb", 64'(oRs1Data), 64'h22);

        // load-use on rs2 only stalls when rs2 is actually read
        idle(); issue(5'd0, 5'd3, 32'h50); iRs1Used = 0;
        iExRdWrite = 1; iExIsLoad = 1; iExRdAddr = 5'd3; tick();
        chk("lu_bubble", 64'(oValid), 64'd0);
        chk("lu_cnt", 64'(oStallCnt), 64'd1);
        iRs2Used = 0; tick();
        chk("lu_nouse", 64'(oValid), 64'd1);
        chk("lu_cnt_hold", 64'(oStallCnt), 64'd1);

        // backpressure: bundle at 0x100 must hold for 4 cycles, then drain straight into 0x200
        idle(); issue(5'd5, 5'd7, 32'h100); tick();
        issue(5'd7, 5'd5, 32'h200); iReady = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_pc", 64'(oPc), 64'h100);
        end
        iReady = 1; tick();
        chk("bp_next", 64'(oPc), 64'h200);
        chk("bp_next_v", 64'(oValid), 64'd1);

        // flush while FULL with a waiting instruction
        iReady = 0; issue(5'd1, 5'd2, 32'h300); iFlush = 1; tick();
        chk("flush_v", 64'(oValid), 64'd0);
        chk("flush_cnt", 64'(oStallCnt), 64'd1);

        // async reset in the middle of a hold
        idle(); issue(5'd5, 5'd0, 32'h400); tick();
        iReady = 0; iValid = 0; tick();
        #2 iRst = 0;
        #1;
        chk("midrst_v", 64'(oValid), 64'd0);
        chk("midrst_cnt", 64'(oStallCnt), 64'd0);
        model_reset();
        @(negedge iClk); iRst = 1;
        @(posedge iClk); #1;

        // random traffic on a narrow register window so hazards and forwards collide often
        for (int n = 0; n < 600; n++) begin
            iValid     = ($urandom_range(0, 3) != 0);
            iRs1Addr   = 5'($urandom_range(0, 7));
            iRs2Addr   = 5'($urandom_range(0, 7));
            iRdAddr    = 5'($urandom);
            iRs1Used   = 1'($urandom);
            iRs2Used   = 1'($urandom);
            iRdWrite   = 1'($urandom);
            iIsLoad    = 1'($urandom);
            iImm       = $urandom;
            iPc        = $urandom;
            iCtrl      = 24'($urandom);
            iFlush     = ($urandom_range(0, 15) == 0);
            iExRdWrite = 1'($urandom);
            iExIsLoad  = 1'($urandom);
            iExRdAddr  = 5'($urandom_range(0, 7));
            iExData    = $urandom;
            iWbEn      = 1'($urandom);
            iWbAddr    = 5'($urandom_range(0, 7));
            iWbData    = $urandom;
            iReady     = ($urandom_range(0, 2) != 0);
            tick();
        end
        chk("sat_cnt", 64'(oStallCnt), 64'((1 << SW) - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
